exu_cdb_wb_buf: RTL and testbench
=================================

Name: exu_cdb_wb_buf

Overview:
- Execution-unit-side transmitter for the exu-to-CDB writeback handshake (req/rdy/tag/wdata).
- Sits between an execution unit's result stage (ALU, MDU or LSU) and the CDB arbiter.
- Queues completed results in a small FIFO and presents the oldest on req/tag/wdata until the arbiter grants it with rdy.
- Lets the unit keep retiring results while it loses CDB arbitration; counts cycles lost to arbitration.

Parameters:
- TAG_W, 4: width of the ROB/physical tag carried with each result.
- DATA_W, 32: result data width.
- DEPTH, 4: FIFO entries; power of two, >= 2.
- CNT_W, 16: width of the stall statistics counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous squash of all buffered results (mispredict recovery).
- res_vld  in  1  execution unit presents a completed result.
- res_tag  in  TAG_W  tag of the presented result.
- res_data  in  DATA_W  data of the presented result.
- res_rdy  out  1  buffer can accept a result this cycle.
- cdb_req  out  1  exu2cdb req: head entry valid.
- cdb_tag  out  TAG_W  exu2cdb tag: head entry tag.
- cdb_wdata  out  DATA_W  exu2cdb wdata: head entry data.
- cdb_rdy  in  1  exu2cdb rdy: grant from the CDB arbiter.
- occupancy  out  $clog2(DEPTH)+1  current entry count.
- stall_cnt  out  CNT_W  saturating count of cycles with cdb_req=1 and cdb_rdy=0.

Behaviour:
- Reset (async, rst=1):
  - wr_ptr, rd_ptr and count go to 0; stall_cnt goes to 0.
  - Outputs: cdb_req=0, cdb_tag=0, cdb_wdata=0, res_rdy=1, occupancy=0.
  - Entry storage need not be reset.
- Push: accepted when res_vld && res_rdy at a clock edge; entry written at wr_ptr, wr_ptr increments.
- Pop: occurs when cdb_req && cdb_rdy at a clock edge; rd_ptr increments.
- Pointers wrap modulo DEPTH. count is tracked separately, so full and empty are unambiguous.
- res_rdy = (count < DEPTH).
  - Combinational on registered state only; no dependence on cdb_rdy, so there is no path from cdb_rdy to res_rdy.
  - When full, a push is refused even if a pop happens in the same cycle.
- cdb_req = (count != 0).
  - Must never depend combinationally on cdb_rdy; the arbiter derives rdy from other units' req, and a dependence would create a loop.
- cdb_tag/cdb_wdata:
  - Equal the head entry when cdb_req=1, else 0.
  - Held stable while cdb_req=1 && cdb_rdy=0.
- Latency: a result pushed into an empty buffer raises cdb_req the next cycle. There is no bypass.
- Simultaneous push and pop, count between 1 and DEPTH-1: count unchanged, both pointers advance, and ordering is preserved (FIFO).
- Pop with count=1 and no push: cdb_req deasserts the next cycle.
- flush=1 at an edge:
  - count, wr_ptr and rd_ptr go to 0.
  - A same-cycle push is discarded; a same-cycle pop is irrelevant.
  - cdb_req=0 the next cycle.
  - stall_cnt is not cleared.
- stall_cnt increments by 1 on each edge where cdb_req && !cdb_rdy, and saturates at 2^CNT_W-1.
- occupancy = count.
- Reset asserted mid-operation: all queued entries are dropped immediately. Outputs go to their reset values asynchronously, without waiting for a clock edge.
- Illegal inputs: res_vld while res_rdy=0 is ignored. The producer must hold the result until accepted.

Test Plan:
1. Push tag=3/data=0xDEADBEEF into an empty buffer with cdb_rdy=1:
   - req=1 with tag 3 / data 0xDEADBEEF exactly one cycle later.
   - Popped on that edge; req=0 after; occupancy returns to 0.
2. cdb_rdy=0, push 4 results (tags 1..4):
   - res_rdy=0 after the 4th push; a 5th res_vld is refused.
   - req held with tag 1 and stable data; stall_cnt increments each cycle.
   - Raise cdb_rdy: tags 1,2,3,4 emerge in order on consecutive cycles.
3. Steady state, count=2, push and pop every cycle for 10 cycles:
   - occupancy stays 2; output tag sequence equals input sequence delayed by 2 grants.
4. count=3 with flush and push in the same cycle:
   - Next cycle req=0, occupancy=0; the pushed result never appears on the CDB.
   - stall_cnt retains its value.
5. Assert rst asynchronously between edges with count=2:
   - req, tag and wdata drop to 0 immediately; occupancy=0.
   - After release, a new push appears normally one cycle later.
6. Force 2^CNT_W+5 stall cycles (CNT_W overridden to 4):
   - stall_cnt saturates at 15 and does not wrap.

Source files
------------

// File: rtl/exu_cdb_wb_buf.sv
// exu_cdb_wb_buf
//   Writeback buffer between an execution unit's result stage and the CDB
//   arbiter. Completed results are queued in a small FIFO; the oldest entry is
//   offered on cdb_req/cdb_tag/cdb_wdata until the arbiter grants it with
//   cdb_rdy. Cycles spent requesting without a grant are counted in stall_cnt.
//
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     flush             synchronous squash of every buffered result
//     res_vld/tag/data  result offered by the execution unit
//     res_rdy           buffer can take a result this cycle
//     cdb_req/tag/wdata head entry presented to the CDB arbiter
//     cdb_rdy           grant from the CDB arbiter
//     occupancy         current number of buffered entries
//     stall_cnt         saturating count of cycles with cdb_req && !cdb_rdy
module exu_cdb_wb_buf #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       res_vld,
    input  logic [TAG_W-1:0]           res_tag,
    input  logic [DATA_W-1:0]          res_data,
    output logic                       res_rdy,
    output logic                       cdb_req,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_wdata,
    input  logic                       cdb_rdy,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    logic [TAG_W-1:0]  tag_mem_q  [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q,  count_d;
    logic [CNT_W-1:0] stall_q,  stall_d;

    logic push;
    logic pop;

    // Both handshakes depend on registered state only, so neither ready nor
    // request has a combinational path from cdb_rdy.
    assign res_rdy   = (count_q < FULL_CNT);
    assign cdb_req   = (count_q != '0);
    assign occupancy = count_q;
    assign stall_cnt = stall_q;

    assign push = res_vld && res_rdy;
    assign pop  = cdb_req && cdb_rdy;

    always_comb begin
        cdb_tag   = '0;
        cdb_wdata = '0;
        if (cdb_req) begin
            cdb_tag   = tag_mem_q[rd_ptr_q];
            cdb_wdata = data_mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + OCC_W'(1);
                2'b01:   count_d = count_q - OCC_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Flush deliberately leaves the statistics counter alone.
    always_comb begin
        stall_d = stall_q;
        if (cdb_req && !cdb_rdy && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    // Storage is not reset; an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q]  <= res_tag;
            data_mem_q[wr_ptr_q] <= res_data;
        end
    end

endmodule

// File: tb/tb_exu_cdb_wb_buf.sv
module tb_exu_cdb_wb_buf;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        res_vld;
    logic [3:0]  res_tag;
    logic [31:0] res_data;
    logic        res_rdy;
    logic        cdb_req;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_wdata;
    logic        cdb_rdy;
    logic [2:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        s_flush;
    logic        s_res_vld;
    logic [3:0]  s_res_tag;
    logic [31:0] s_res_data;
    logic        s_res_rdy;
    logic        s_cdb_req;
    logic [3:0]  s_cdb_tag;
    logic [31:0] s_cdb_wdata;
    logic        s_cdb_rdy;
    logic [2:0]  s_occupancy;
    logic [3:0]  s_stall_cnt;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] data;
    } entry_t;

    entry_t sb[$];
    int     tests;
    int     fails;
    int     exp_stall;

    exu_cdb_wb_buf #(.TAG_W(4), .DATA_W(32), .DEPTH(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .res_vld(res_vld), .res_tag(res_tag), .res_data(res_data),
        .res_rdy(res_rdy), .cdb_req(cdb_req), .cdb_tag(cdb_tag),
        .cdb_wdata(cdb_wdata), .cdb_rdy(cdb_rdy),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    exu_cdb_wb_buf #(.TAG_W(4), .DATA_W(32), .DEPTH(4), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .flush(s_flush),
        .res_vld(s_res_vld), .res_tag(s_res_tag), .res_data(s_res_data),
        .res_rdy(s_res_rdy), .cdb_req(s_cdb_req), .cdb_tag(s_cdb_tag),
        .cdb_wdata(s_cdb_wdata), .cdb_rdy(s_cdb_rdy),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] t, input logic [31:0] d);
        entry_t e;
        e.tag  = t;
        e.data = d;
        sb.push_back(e);
    endtask

    // Monitor: every grant seen ahead of the edge must match the oldest
    // expected entry.
    always @(negedge clk) begin
        if (!rst && cdb_req && cdb_rdy) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_grant: got tag %0h data %0h expected no request", cdb_tag, cdb_wdata);
            end else begin
                entry_t e;
                e = sb.pop_front();
                chk("grant_tag", 32'(cdb_tag), 32'(e.tag));
                chk("grant_data", cdb_wdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0; fails = 0; exp_stall = 0;
        rst = 1'b1; flush = 1'b0; res_vld = 1'b0; res_tag = '0; res_data = '0; cdb_rdy = 1'b0;
        s_flush = 1'b0; s_res_vld = 1'b0; s_res_tag = '0; s_res_data = '0; s_cdb_rdy = 1'b0;
        #12;
        chk("rst_req", 32'(cdb_req), 32'd0);
        chk("rst_tag", 32'(cdb_tag), 32'd0);
        chk("rst_wdata", cdb_wdata, 32'd0);
        chk("rst_res_rdy", 32'(res_rdy), 32'd1);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        rst = 1'b0;

        // 1: single result, immediate grant
        cyc();
        res_vld = 1'b1; res_tag = 4'd3; res_data = 32'hDEADBEEF; cdb_rdy = 1'b1;
        push_exp(4'd3, 32'hDEADBEEF);
        cyc();
        res_vld = 1'b0;
        chk("t1_req", 32'(cdb_req), 32'd1);
        chk("t1_tag", 32'(cdb_tag), 32'd3);
        chk("t1_occ", 32'(occupancy), 32'd1);
        cyc();
        chk("t1_req_after", 32'(cdb_req), 32'd0);
        chk("t1_occ_after", 32'(occupancy), 32'd0);

        // 2: fill while losing arbitration, then drain in order
        cdb_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            res_vld = 1'b1; res_tag = 4'(i); res_data = 32'hA0000000 + 32'(i);
            push_exp(4'(i), 32'hA0000000 + 32'(i));
            cyc();
            if (i > 1) exp_stall++;
        end
        chk("t2_res_rdy_full", 32'(res_rdy), 32'd0);
        chk("t2_occ_full", 32'(occupancy), 32'd4);
        chk("t2_stall", 32'(stall_cnt), 32'(exp_stall));
        res_tag = 4'd5; res_data = 32'hA0000005;
        for (int i = 0; i < 3; i++) begin
            cyc();
            exp_stall++;
            chk("t2_hold_tag", 32'(cdb_tag), 32'd1);
            chk("t2_hold_data", cdb_wdata, 32'hA0000001);
            chk("t2_hold_occ", 32'(occupancy), 32'd4);
            chk("t2_hold_stall", 32'(stall_cnt), 32'(exp_stall));
        end
        res_vld = 1'b0; cdb_rdy = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            cyc();
            chk("t2_drain_occ", 32'(occupancy), 32'(i));
        end

        // 3: steady state at two entries, push and pop every cycle
        cdb_rdy = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            res_vld = 1'b1; res_tag = 4'(i); res_data = 32'hB0000000 + 32'(i);
            push_exp(4'(i), 32'hB0000000 + 32'(i));
            cyc();
            if (i > 1) exp_stall++;
        end
        cdb_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            res_tag = 4'(i + 5); res_data = 32'hC0000000 + 32'(i);
            push_exp(4'(i + 5), 32'hC0000000 + 32'(i));
            cyc();
            chk("t3_occ", 32'(occupancy), 32'd2);
        end
        res_vld = 1'b0;
        cyc();
        cyc();
        chk("t3_occ_drained", 32'(occupancy), 32'd0);
        chk("t3_stall", 32'(stall_cnt), 32'(exp_stall));

        // 4: flush with a same-cycle push at three entries
        cdb_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            res_vld = 1'b1; res_tag = 4'(i + 7); res_data = 32'hD0000000 + 32'(i);
            push_exp(4'(i + 7), 32'hD0000000 + 32'(i));
            cyc();
            if (i > 0) exp_stall++;
        end
        chk("t4_occ_pre", 32'(occupancy), 32'd3);
        flush = 1'b1; res_tag = 4'd15; res_data = 32'hBADBAD00;
        sb.delete();
        cyc();
        exp_stall++;
        flush = 1'b0; res_vld = 1'b0;
        chk("t4_req", 32'(cdb_req), 32'd0);
        chk("t4_occ", 32'(occupancy), 32'd0);
        chk("t4_stall_kept", 32'(stall_cnt), 32'(exp_stall));
        cdb_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4_req_idle", 32'(cdb_req), 32'd0);
        end

        // 5: asynchronous reset with two entries queued
        cdb_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            res_vld = 1'b1; res_tag = 4'(2 + 4 * i); res_data = 32'hE0000000 + 32'(i);
            cyc();
        end
        res_vld = 1'b0;
        chk("t5_occ_pre", 32'(occupancy), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_req", 32'(cdb_req), 32'd0);
        chk("t5_tag", 32'(cdb_tag), 32'd0);
        chk("t5_wdata", cdb_wdata, 32'd0);
        chk("t5_occ", 32'(occupancy), 32'd0);
        chk("t5_res_rdy", 32'(res_rdy), 32'd1);
        cyc();
        rst = 1'b0;
        exp_stall = 0;
        res_vld = 1'b1; res_tag = 4'd4; res_data = 32'h12345678; cdb_rdy = 1'b1;
        push_exp(4'd4, 32'h12345678);
        cyc();
        res_vld = 1'b0;
        chk("t5_req_new", 32'(cdb_req), 32'd1);
        cyc();
        chk("t5_occ_new", 32'(occupancy), 32'd0);
        chk("t5_stall_cleared", 32'(stall_cnt), 32'(exp_stall));

        // 6: saturation of a 4-bit stall counter over 21 stalled cycles
        s_res_vld = 1'b1; s_res_tag = 4'd1; s_res_data = 32'h1; s_cdb_rdy = 1'b0;
        cyc();
        s_res_vld = 1'b0;
        for (int i = 0; i < 21; i++) begin
            cyc();
            chk("t6_stall_sat", 32'(s_stall_cnt), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        chk("t6_req_held", 32'(s_cdb_req), 32'd1);

        cdb_rdy = 1'b0;
        cyc();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
